// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the shifter sequencing stage: sizes, op codes, FSM states.
package shift_ctrl_pkg;

  localparam int unsigned WIDTH       = 32;
  localparam int unsigned SHIFT_WIDTH = 5;
  localparam int unsigned OPS         = 2;
  localparam int unsigned CNT_WIDTH   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [OPS-1:0] {
    LEFT_SHIFTA  = 2'b00,
    LEFT_SHIFTL  = 2'b01,
    RIGHT_SHIFTA = 2'b10,
    RIGHT_SHIFTL = 2'b11
  } op_t;

  typedef struct packed {
    logic [WIDTH-1:0]       data;
    logic [SHIFT_WIDTH-1:0] shift;
    logic [OPS-1:0]         op;
  } cmd_t;

endpackage

// File: rtl/shift_ctrl_if.sv
// Command, result and shifter-side signals of shift_ctrl; slave is the controller's view.
interface shift_ctrl_if
  import shift_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH       = shift_ctrl_pkg::WIDTH,
  parameter int unsigned SHIFT_WIDTH = shift_ctrl_pkg::SHIFT_WIDTH,
  parameter int unsigned OPS         = shift_ctrl_pkg::OPS,
  parameter int unsigned CNT_WIDTH   = shift_ctrl_pkg::CNT_WIDTH
);

  logic                   i_valid;
  logic                   o_ready;
  logic [WIDTH-1:0]       i_data;
  logic [SHIFT_WIDTH-1:0] i_shift;
  logic [OPS-1:0]         i_op;

  logic [WIDTH-1:0]       o_sh_data;
  logic [SHIFT_WIDTH-1:0] o_sh_shift;
  logic [OPS-1:0]         o_sh_op;
  logic                   o_sh_start;
  logic [WIDTH-1:0]       i_sh_result;

  logic                   o_valid;
  logic                   i_ready;
  logic [WIDTH-1:0]       o_result;
  logic [OPS-1:0]         o_op;
  logic                   o_zero;
  logic [CNT_WIDTH-1:0]   o_count;

  modport master (
    output i_valid, i_data, i_shift, i_op, i_sh_result, i_ready,
    input  o_ready, o_sh_data, o_sh_shift, o_sh_op, o_sh_start,
           o_valid, o_result, o_op, o_zero, o_count
  );

  modport slave (
    input  i_valid, i_data, i_shift, i_op, i_sh_result, i_ready,
    output o_ready, o_sh_data, o_sh_shift, o_sh_op, o_sh_start,
           o_valid, o_result, o_op, o_zero, o_count
  );

endinterface

// File: rtl/shift_ctrl.sv
// Sequencer around the combinational shifter: accept, one-cycle execute, hold result for downstream.
module shift_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH       = shift_ctrl_pkg::WIDTH,
  parameter int unsigned SHIFT_WIDTH = shift_ctrl_pkg::SHIFT_WIDTH,
  parameter int unsigned OPS         = shift_ctrl_pkg::OPS,
  parameter int unsigned CNT_WIDTH   = shift_ctrl_pkg::CNT_WIDTH
) (
  input  logic          i_clk,
  input  logic          i_rst,
  shift_ctrl_if.slave   bus
);

  state_t                 r_state;
  state_t                 w_next;
  logic                   w_ready;
  logic                   w_start;
  logic                   w_accept;
  logic                   w_capture;
  logic                   w_deliver;

  logic [WIDTH-1:0]       r_sh_data;
  logic [SHIFT_WIDTH-1:0] r_sh_shift;
  logic [OPS-1:0]         r_sh_op;
  logic [WIDTH-1:0]       r_result;
  logic [OPS-1:0]         r_op;
  logic                   r_zero;
  logic [CNT_WIDTH-1:0]   r_count;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state and handshake strobes; o_ready never looks at i_valid
  always_comb begin
    w_next    = r_state;
    w_ready   = 1'b0;
    w_start   = 1'b0;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_deliver = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (bus.i_valid) begin
          w_accept = 1'b1;
          w_next   = EXEC;
        end
      end
      EXEC: begin
        w_start   = 1'b1;
        w_capture = 1'b1;
        w_next    = DONE;
      end
      DONE: begin
        w_ready = bus.i_ready;
        if (bus.i_ready) begin
          w_deliver = 1'b1;
          if (bus.i_valid) begin
            w_accept = 1'b1;
            w_next   = EXEC;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand registers feed the shifter and hold until the next accept
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sh_data  <= '0;
      r_sh_shift <= '0;
      r_sh_op    <= '0;
    end else if (w_accept) begin
      r_sh_data  <= bus.i_data;
      r_sh_shift <= bus.i_shift;
      r_sh_op    <= bus.i_op;
    end
  end

  // Result capture must happen while start is high, i.e. in EXEC
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_result <= '0;
      r_op     <= '0;
      r_zero   <= 1'b0;
    end else if (w_capture) begin
      r_result <= bus.i_sh_result;
      r_op     <= r_sh_op;
      r_zero   <= (bus.i_sh_result == '0);
    end
  end

  // Delivered-result counter, wraps naturally
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)          r_count <= '0;
    else if (w_deliver) r_count <= r_count + CNT_WIDTH'(1);
  end

  assign bus.o_ready    = w_ready;
  assign bus.o_sh_start = w_start;
  assign bus.o_sh_data  = r_sh_data;
  assign bus.o_sh_shift = r_sh_shift;
  assign bus.o_sh_op    = r_sh_op;
  assign bus.o_valid    = (r_state == DONE);
  assign bus.o_result   = r_result;
  assign bus.o_op       = r_op;
  assign bus.o_zero     = r_zero;
  assign bus.o_count    = r_count;

endmodule

// File: tb/tb_shift_ctrl.sv
// Testbench for shift_ctrl with a stand-in shifter and a queue-based reference model.
module tb_shift_ctrl;
  import shift_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_ctrl_if bus ();

  shift_ctrl dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [CNT_WIDTH-1:0] exp_count = '0;

  // Behavioural shift by op code
  function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d,
                                                  input logic [SHIFT_WIDTH-1:0] s,
                                                  input logic [OPS-1:0] op);
    case (op)
      2'b00, 2'b01: return d << s;
      2'b10:        return WIDTH'($signed(d) >>> s);
      default:      return d >> s;
    endcase
  endfunction

  // Stand-in shifter: output only follows its inputs while start is high
  always @* begin
    if (bus.o_sh_start) bus.i_sh_result = ref_shift(bus.o_sh_data, bus.o_sh_shift, bus.o_sh_op);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full transaction with downstream always ready; checks cycle-exact latency
  task automatic do_op(input logic [WIDTH-1:0] d, input logic [SHIFT_WIDTH-1:0] s,
                       input logic [OPS-1:0] op, input logic [WIDTH-1:0] exp_r, input string tag);
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_data = d; bus.i_shift = s; bus.i_op = op; bus.i_ready = 1'b1;
    #1;
    for (int n = 0; n < 20 && !bus.o_ready; n++) begin @(negedge clk); #1; end
    check({tag, "_ready"}, bus.o_ready, 1);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    check({tag, "_start"}, bus.o_sh_start, 1);
    check({tag, "_valid_exec"}, bus.o_valid, 0);
    check({tag, "_sh_data"}, bus.o_sh_data, d);
    @(posedge clk); #1;
    check({tag, "_valid"}, bus.o_valid, 1);
    check({tag, "_result"}, bus.o_result, exp_r);
    check({tag, "_zero"}, bus.o_zero, (exp_r == 0));
    check({tag, "_op"}, bus.o_op, op);
    check({tag, "_start_done"}, bus.o_sh_start, 0);
    @(posedge clk); #1;
    exp_count++;
    check({tag, "_count"}, bus.o_count, exp_count);
    check({tag, "_valid_after"}, bus.o_valid, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.i_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_count = '0;
    @(posedge clk); #1;
  endtask

  cmd_t q[$];
  cmd_t c;
  logic [WIDTH-1:0] held_result;
  logic [WIDTH-1:0] b2b_d [4];
  logic [SHIFT_WIDTH-1:0] b2b_s [4];
  logic [OPS-1:0] b2b_o [4];

  initial begin
    rst = 1'b1;
    bus.i_valid = 1'b0; bus.i_data = '0; bus.i_shift = '0; bus.i_op = '0; bus.i_ready = 1'b0;
    #12;
    check("rst_valid", bus.o_valid, 0);
    check("rst_start", bus.o_sh_start, 0);
    check("rst_result", bus.o_result, 0);
    check("rst_op", bus.o_op, 0);
    check("rst_zero", bus.o_zero, 0);
    check("rst_count", bus.o_count, 0);
    check("rst_sh_data", bus.o_sh_data, 0);
    check("rst_ready", bus.o_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    // Directed operations with constant expectations
    do_op(32'h0000_0001, 5'd4,  2'b01, 32'h0000_0010, "lsl");
    do_op(32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000, "asr");
    do_op(32'h8000_0000, 5'd4,  2'b11, 32'h0800_0000, "lsr");
    do_op(32'h0000_0001, 5'd1,  2'b11, 32'h0000_0000, "zero");
    do_op(32'h8000_0000, 5'd31, 2'b11, 32'h0000_0001, "max");
    do_op(32'hDEAD_BEEF, 5'd0,  2'b00, 32'hDEAD_BEEF, "pass");
    do_op(32'h8000_0001, 5'd31, 2'b00, 32'h8000_0000, "asl_max");

    // Backpressure: hold downstream off for 5 cycles in DONE
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_data = 32'h1234_5678; bus.i_shift = 5'd8; bus.i_op = 2'b01; bus.i_ready = 1'b0;
    #1;
    check("bp_ready_idle", bus.o_ready, 1);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    @(posedge clk); #1;
    held_result = 32'h3456_7800;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", bus.o_valid, 1);
      check("bp_result", bus.o_result, held_result);
      check("bp_op", bus.o_op, 2'b01);
      check("bp_ready", bus.o_ready, 0);
      check("bp_count", bus.o_count, exp_count);
      @(posedge clk); #1;
    end
    bus.i_ready = 1'b1; bus.i_valid = 1'b1;
    bus.i_data = 32'hF000_0000; bus.i_shift = 5'd2; bus.i_op = 2'b10;
    #1;
    check("bp_ready_release", bus.o_ready, 1);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    exp_count++;
    check("bp_count_release", bus.o_count, exp_count);
    check("bp_exec_start", bus.o_sh_start, 1);
    check("bp_exec_data", bus.o_sh_data, 32'hF000_0000);
    check("bp_exec_valid", bus.o_valid, 0);
    @(posedge clk); #1;
    check("bp2_valid", bus.o_valid, 1);
    check("bp2_result", bus.o_result, 32'hFC00_0000);
    @(posedge clk); #1;
    exp_count++;
    check("bp2_count", bus.o_count, exp_count);

    // Back-to-back with both sides always ready
    apply_reset();
    b2b_d = '{32'h0000_00FF, 32'h8000_0000, 32'hCAFE_F00D, 32'h0000_0003};
    b2b_s = '{5'd4, 5'd3, 5'd16, 5'd2};
    b2b_o = '{2'b01, 2'b10, 2'b11, 2'b11};
    bus.i_ready = 1'b1;
    begin
      int sent = 0;
      int got = 0;
      int last = -1;
      for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
        if (sent < 4) begin
          bus.i_valid = 1'b1; bus.i_data = b2b_d[sent]; bus.i_shift = b2b_s[sent]; bus.i_op = b2b_o[sent];
        end else begin
          bus.i_valid = 1'b0;
        end
        #1;
        if (bus.o_valid) begin
          check("b2b_result", bus.o_result, ref_shift(b2b_d[got], b2b_s[got], b2b_o[got]));
          check("b2b_op", bus.o_op, b2b_o[got]);
          if (got > 0) check("b2b_gap", cyc - last, 2);
          last = cyc;
          got++;
        end
        if (bus.i_valid && bus.o_ready) sent++;
        @(posedge clk); #1;
      end
      bus.i_valid = 1'b0;
      check("b2b_results", got, 4);
      exp_count = exp_count + CNT_WIDTH'(4);
      check("b2b_count", bus.o_count, 16'd4);
    end

    // Asynchronous reset in the middle of EXEC
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_data = 32'h0000_0101; bus.i_shift = 5'd1; bus.i_op = 2'b01;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    check("rexec_start_pre", bus.o_sh_start, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rexec_start", bus.o_sh_start, 0);
    check("rexec_valid", bus.o_valid, 0);
    check("rexec_result", bus.o_result, 0);
    check("rexec_count", bus.o_count, 0);
    check("rexec_sh_data", bus.o_sh_data, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_count = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rexec_no_valid", bus.o_valid, 0);
    end
    do_op(32'h0000_0003, 5'd2, 2'b01, 32'h0000_000C, "post_rst");

    // Randomized traffic against a queue scoreboard
    begin
      logic acc = 1'b1;
      bus.i_valid = 1'b0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
        bus.i_ready = ($urandom_range(0, 3) != 0);
        if (acc || !bus.i_valid) begin
          bus.i_valid = ($urandom_range(0, 2) != 0);
          bus.i_data  = ($urandom_range(0, 3) == 0) ? (WIDTH'(1) << $urandom_range(0, 31)) : WIDTH'($urandom);
          bus.i_shift = SHIFT_WIDTH'($urandom);
          bus.i_op    = OPS'($urandom);
        end
        #1;
        check("rnd_count", bus.o_count, exp_count);
        if (bus.o_valid) begin
          if (q.size() == 0) begin
            check("rnd_spurious_valid", bus.o_valid, 0);
          end else begin
            c = q[0];
            check("rnd_result", bus.o_result, ref_shift(c.data, c.shift, c.op));
            check("rnd_op", bus.o_op, c.op);
            check("rnd_zero", bus.o_zero, (ref_shift(c.data, c.shift, c.op) == 0));
            if (bus.i_ready) begin
              void'(q.pop_front());
              exp_count++;
            end
          end
        end
        acc = bus.i_valid && bus.o_ready;
        if (acc) q.push_back('{data: bus.i_data, shift: bus.i_shift, op: bus.i_op});
        @(posedge clk); #1;
      end
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      for (int n = 0; n < 20 && q.size() > 0; n++) begin
        #1;
        if (bus.o_valid) begin
          c = q[0];
          check("drain_result", bus.o_result, ref_shift(c.data, c.shift, c.op));
          void'(q.pop_front());
          exp_count++;
        end
        @(posedge clk); #1;
      end
      check("drain_empty", q.size(), 0);
      check("drain_count", bus.o_count, exp_count);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_ctrl.md
Name: shift_ctrl

Overview:
- Sequencing stage that wraps the combinational shifter.
- Accepts shift commands on a valid/ready handshake and registers the operands.
- Drives the shifter's data/shift/op/start inputs for exactly one cycle, then captures the shifter result.
- Presents the result downstream on a valid/ready handshake with backpressure, plus zero flag and completed-op counter.

Parameters:
- WIDTH, 32, data width; must match the shifter.
- SHIFT_WIDTH, 5, shift-amount width; equals log2(WIDTH).
- OPS, 2, op-code width.
- CNT_WIDTH, 16, width of the completed-operation counter.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  upstream command valid.
- o_ready  out  1  command accepted when i_valid && o_ready at a rising edge.
- i_data  in  WIDTH  operand.
- i_shift  in  SHIFT_WIDTH  shift amount.
- i_op  in  OPS  op: 00 left arith, 01 left logical, 10 right arith, 11 right logical.
- o_sh_data  out  WIDTH  registered operand to shifter i_data.
- o_sh_shift  out  SHIFT_WIDTH  registered amount to shifter i_shift.
- o_sh_op  out  OPS  registered op to shifter i_op.
- o_sh_start  out  1  shifter i_start.
- i_sh_result  in  WIDTH  shifter o_result.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream ready.
- o_result  out  WIDTH  captured result.
- o_op  out  OPS  op that produced o_result.
- o_zero  out  1  1 when o_result == 0.
- o_count  out  CNT_WIDTH  results delivered since reset.

Behaviour:
- Reset (async, i_rst=1): state IDLE. o_valid=0, o_sh_start=0, o_result=0, o_op=0, o_zero=0, o_count=0. Operand registers and o_sh_* = 0.
- A reset asserted mid-operation discards the in-flight command; no result is delivered.
- State IDLE:
  - o_ready=1.
  - On accept, latch i_data/i_shift/i_op into o_sh_*; go to EXEC.
- State EXEC (exactly one cycle):
  - o_sh_start=1, o_ready=0.
  - At the closing edge, capture i_sh_result into o_result, o_sh_op into o_op, and (i_sh_result==0) into o_zero; go to DONE.
  - The shifter only updates while start is high, so capture must happen in EXEC.
- State DONE:
  - o_valid=1; o_result, o_op and o_zero are held stable until handshake.
  - On i_ready: o_count increments (wraps all-ones -> 0). Then:
    - if i_valid also accepted the same cycle, latch the new command and go to EXEC;
    - otherwise go to IDLE.
- o_ready is combinational: 1 in IDLE, equal to i_ready in DONE, 0 in EXEC. No combinational path exists from i_valid to o_ready.
- o_sh_start is 0 in every state except EXEC.
- Timing:
  - Latency: command accepted at edge N -> o_valid high after edge N+1.
  - Peak throughput: one op per 2 cycles with i_ready held high.
- o_sh_* stay stable from accept until the next accept, so the shifter output holds.
- Shift amount 0 passes data through unchanged. Amounts up to WIDTH-1 are legal; no range check is needed.

Decomposition:
- Shared include alu_defs.vh holds:
  - op encodings (LEFT_SHIFTA/LEFT_SHIFTL/RIGHT_SHIFTA/RIGHT_SHIFTL);
  - WIDTH / SHIFT_WIDTH / OPS defaults, guarded by ifndef;
  - state encodings IDLE=2'd0, EXEC=2'd1, DONE=2'd2.
- No sub-module. The shifter is instantiated beside shift_ctrl at the ALU top level and connected through the o_sh_* / i_sh_result ports. The test bench instantiates both.

Test Plan:
- Left logical: i_data=0x00000001, shift=4, op=01, i_ready=1 -> o_result=0x00000010, o_zero=0, o_valid one edge after EXEC, o_count=1.
- Right arithmetic: i_data=0x80000000, shift=4, op=10 -> 0xF8000000. Right logical, same operands, op=11 -> 0x08000000.
- Zero and max shift:
  - 0x00000001 right logical by 1 -> o_result=0, o_zero=1.
  - 0x80000000 right logical by 31 -> 0x00000001.
- Backpressure: i_ready=0 for 5 cycles in DONE -> o_valid, o_result and o_op stable, o_ready=0, o_count unchanged. On i_ready=1 with i_valid=1, the new command is accepted in the same cycle and EXEC follows immediately.
- Back-to-back: 4 commands with i_valid and i_ready held high -> one result every 2 cycles, in order, o_count=4.
- Reset during EXEC: assert i_rst asynchronously between edges -> outputs zero immediately, no o_valid afterwards. Next command completes normally with o_count=1.
